// File: rtl/pong_game_ctrl_if.sv
// Pong game-logic bundle: timing/button inputs toward the controller and
// paddle/ball/status outputs toward the drawer.
//   master: drives sx, sy, btn_up, btn_down; observes all outputs
//   slave : the game controller itself
interface pong_game_ctrl_if;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] paddle0_pos;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [1:0] game_state;
  logic [3:0] miss_count;
  logic       frame_update;

  modport master (
    output sx, sy, btn_up, btn_down,
    input  paddle0_pos, ball_pos_x, ball_pos_y,
    input  game_state, miss_count, frame_update
  );

  modport slave (
    input  sx, sy, btn_up, btn_down,
    output paddle0_pos, ball_pos_x, ball_pos_y,
    output game_state, miss_count, frame_update
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: updates paddle/ball once per frame at the start of
// vertical blanking (sx==0, sy==V_ACTIVE) and runs the SERVE/PLAY/MISS FSM.
//   clk_pxl : pixel clock
//   reset   : asynchronous active-high reset
//   io      : slave side of pong_game_ctrl_if (sx/sy/buttons in,
//             paddle0_pos, ball_pos_x/y, game_state, miss_count,
//             frame_update out)
module pong_game_ctrl #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned PADDLE_X     = 16,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input logic clk_pxl,
  input logic reset,
  pong_game_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [10:0] PAD_RST  = 11'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [10:0] PAD_MAX  = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] PAD_STEP = 11'(PADDLE_SPEED);
  localparam logic [10:0] PAD_HGT  = 11'(PADDLE_H);
  localparam logic [10:0] X_CTR    = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] Y_CTR    = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] X_FACE   = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] STEP     = 11'(BALL_SPEED);
  localparam logic [10:0] BSIZE    = 11'(BALL_SIZE);
  localparam logic [9:0]  TICK_Y   = 10'(V_ACTIVE);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  MISS_LAST  = 8'(MISS_FRAMES - 1);

  logic       up_s1_q, up_s2_q;
  logic       dn_s1_q, dn_s2_q;

  logic [9:0] pad_q, pad_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_q, dx_d;   // 1 = moving right
  logic       dy_q, dy_d;   // 1 = moving down
  state_t     st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] miss_q, miss_d;
  logic       fu_q, fu_d;

  logic        tick;
  logic        up_only, dn_only;
  logic [10:0] pad11, x11, y11;
  logic [10:0] pad_dn;
  logic        at_face, hit;

  assign tick    = (io.sx == 10'd0) && (io.sy == TICK_Y);
  assign up_only = up_s2_q & ~dn_s2_q;
  assign dn_only = dn_s2_q & ~up_s2_q;

  assign pad11  = {1'b0, pad_q};
  assign x11    = {1'b0, x_q};
  assign y11    = {1'b0, y_q};
  assign pad_dn = pad11 + PAD_STEP;

  // x - STEP <= X_FACE, rearranged so nothing can go negative
  assign at_face = x11 <= (X_FACE + STEP);
  assign hit     = ((y11 + BSIZE) > pad11) && (y11 < (pad11 + PAD_HGT));

  always_comb begin
    pad_d  = pad_q;
    x_d    = x_q;
    y_d    = y_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    miss_d = miss_q;
    fu_d   = tick;

    if (tick) begin
      if (up_only) begin
        pad_d = (pad11 >= PAD_STEP) ? 10'(pad11 - PAD_STEP) : 10'd0;
      end else if (dn_only) begin
        pad_d = (pad_dn > PAD_MAX) ? 10'(PAD_MAX) : 10'(pad_dn);
      end

      unique case (st_q)
        ST_SERVE: begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d = 8'd0;
            st_d  = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_PLAY: begin
          if (dy_q && ((y11 + STEP) >= Y_MAX)) begin
            y_d  = 10'(Y_MAX);
            dy_d = 1'b0;
          end else if (!dy_q && (y11 <= STEP)) begin
            y_d  = 10'd0;
            dy_d = 1'b1;
          end else if (dy_q) begin
            y_d = 10'(y11 + STEP);
          end else begin
            y_d = 10'(y11 - STEP);
          end

          if (dx_q) begin
            if ((x11 + STEP) >= X_MAX) begin
              x_d  = 10'(X_MAX);
              dx_d = 1'b0;
            end else begin
              x_d = 10'(x11 + STEP);
            end
          end else if (at_face) begin
            if (hit) begin
              x_d  = 10'(X_FACE);
              dx_d = 1'b1;
            end else begin
              // ball leaves the field: freeze it where it went out
              x_d    = 10'd0;
              y_d    = y_q;
              dy_d   = dy_q;
              miss_d = (miss_q == 4'hf) ? miss_q : miss_q + 4'd1;
              cnt_d  = 8'd0;
              st_d   = ST_MISS;
            end
          end else begin
            x_d = 10'(x11 - STEP);
          end
        end

        ST_MISS: begin
          if (cnt_q == MISS_LAST) begin
            x_d   = 10'(X_CTR);
            y_d   = 10'(Y_CTR);
            dx_d  = 1'b1;
            cnt_d = 8'd0;
            st_d  = ST_SERVE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        default: begin
          cnt_d = 8'd0;
          st_d  = ST_SERVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pxl or posedge reset) begin
    if (reset) begin
      up_s1_q <= 1'b0;
      up_s2_q <= 1'b0;
      dn_s1_q <= 1'b0;
      dn_s2_q <= 1'b0;
      pad_q   <= 10'(PAD_RST);
      x_q     <= 10'(X_CTR);
      y_q     <= 10'(Y_CTR);
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      st_q    <= ST_SERVE;
      cnt_q   <= 8'd0;
      miss_q  <= 4'd0;
      fu_q    <= 1'b0;
    end else begin
      up_s1_q <= io.btn_up;
      up_s2_q <= up_s1_q;
      dn_s1_q <= io.btn_down;
      dn_s2_q <= dn_s1_q;
      pad_q   <= pad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      fu_q    <= fu_d;
    end
  end

  assign io.paddle0_pos  = pad_q;
  assign io.ball_pos_x   = x_q;
  assign io.ball_pos_y   = y_q;
  assign io.game_state   = st_q;
  assign io.miss_count   = miss_q;
  assign io.frame_update = fu_q;

endmodule
